// File: rtl/l2_pkg.sv
// Shared widths, types and helpers for the L2 host response controller.
// Every file in the slice imports this so the ROB and the top agree on the entry layout.
package l2_pkg;

  localparam int addr_width   = 64;
  localparam int cache_line   = 128;
  localparam int data_width   = cache_line * 8;
  localparam int nstrms       = 64;
  localparam int nstrms_width = $clog2(nstrms);
  localparam int l2_ncl       = 256;
  localparam int l2_ncl_width = $clog2(l2_ncl);
  localparam int ntags        = 32;
  localparam int tag_width    = $clog2(ntags);
  localparam int cnt_width    = tag_width + 1;

  typedef logic [nstrms_width-1:0] sid_t;
  typedef logic [l2_ncl_width-1:0] ptr_t;
  typedef logic [tag_width-1:0]    tag_t;
  typedef logic [cnt_width-1:0]    cnt_t;
  typedef logic [addr_width-1:0]   ea_t;
  typedef logic [data_width-1:0]   data_t;

  typedef struct packed {
    sid_t sid;
    ptr_t ptr;
    logic busy;
    logic done;
  } rob_entry_t;

  // URAM slot advance; written generally so a non-power-of-2 line count still wraps correctly.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(l2_ncl - 1)) ? '0 : p + ptr_t'(1);
  endfunction

endpackage

// File: rtl/l2_tag_rob.sv
// Circular reorder buffer: the tail allocates host tags, the head retires completions in issue order.
// Host responses look an entry up by tag and mark it done once its URAM write has gone out.
module l2_tag_rob
  import l2_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    alloc_v,
  input  logic [nstrms_width-1:0] alloc_sid,
  input  logic [l2_ncl_width-1:0] alloc_ptr,
  output logic [tag_width-1:0]    alloc_tag,
  output logic                    full,
  input  logic [tag_width-1:0]    look_tag,
  output rob_entry_t              look_entry,
  input  logic                    done_v,
  input  logic [tag_width-1:0]    done_tag,
  output logic                    rsp_v,
  input  logic                    rsp_r,
  output logic [nstrms_width-1:0] rsp_sid
);

  sid_t             ent_sid [ntags];
  ptr_t             ent_ptr [ntags];
  logic [ntags-1:0] busy;
  logic [ntags-1:0] done;
  tag_t             head;
  tag_t             tail;
  cnt_t             count;
  logic             retire;

  assign retire    = rsp_v && rsp_r;
  assign full      = (count == cnt_t'(ntags));
  assign alloc_tag = tail;
  assign rsp_v     = busy[head] && done[head];
  assign rsp_sid   = ent_sid[head];

  assign look_entry = '{sid:  ent_sid[look_tag],
                        ptr:  ent_ptr[look_tag],
                        busy: busy[look_tag],
                        done: done[look_tag]};

  // Alloc only targets a free slot and done only targets an outstanding one, so the
  // three updates below never collide on the same index.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      busy  <= '0;
      done  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every read in this block sees the pre-edge state.
      if (retire) begin
        busy[head] <= 1'b0;
        done[head] <= 1'b0;
        head       <= head + tag_t'(1);
      end
      if (done_v) begin
        done[done_tag] <= 1'b1;
      end
      if (alloc_v) begin
        busy[tail] <= 1'b1;
        done[tail] <= 1'b0;
        tail       <= tail + tag_t'(1);
      end
      case ({alloc_v, retire})
        2'b10:   count <= count + cnt_t'(1);
        2'b01:   count <= count - cnt_t'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: payload array is deliberately not reset; busy/done gate every use of it.
  always_ff @(posedge clk) begin
    if (alloc_v) begin
      ent_sid[tail] <= alloc_sid;
      ent_ptr[tail] <= alloc_ptr;
    end
  end

endmodule

// File: rtl/l2_host_rsp_ctrl.sv
// Host-side responder for the L2 stream cache: tags merged line requests, lands returning data
// in URAM at the slot fixed at issue, and hands completions back to L2 control in issue order.
module l2_host_rsp_ctrl
  import l2_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_req_v,
  output logic                    i_req_r,
  input  logic [nstrms_width-1:0] i_req_sid,
  input  logic [addr_width-1:0]   i_req_ea,
  output logic                    o_host_v,
  input  logic                    o_host_r,
  output logic [tag_width-1:0]    o_host_tag,
  output logic [addr_width-1:0]   o_host_ea,
  input  logic                    i_host_v,
  output logic                    i_host_r,
  input  logic [tag_width-1:0]    i_host_tag,
  input  logic [data_width-1:0]   i_host_d,
  output logic                    o_wr_v,
  output logic [nstrms_width-1:0] o_wr_sid,
  output logic [l2_ncl_width-1:0] o_wr_ptr,
  output logic [data_width-1:0]   o_wr_d,
  output logic                    o_rsp_v,
  input  logic                    o_rsp_r,
  output logic [nstrms_width-1:0] o_rsp_sid,
  input  logic                    i_clr_v,
  input  logic [nstrms_width-1:0] i_clr_sid,
  output logic                    o_err
);

  ptr_t       wptr [nstrms];
  logic       rob_full;
  tag_t       alloc_tag;
  rob_entry_t look_entry;
  tag_t       wr_tag;
  logic       accept;
  logic       host_hit;

  assign i_host_r = 1'b1;
  // Full comes from the registered count: a retire this cycle frees the slot only next cycle.
  assign i_req_r  = !rob_full && (!o_host_v || o_host_r);
  assign accept   = i_req_v && i_req_r;
  assign host_hit = i_host_v && look_entry.busy && !look_entry.done;

  l2_tag_rob u_rob (
    .clk        (clk),
    .reset      (reset),
    .alloc_v    (accept),
    .alloc_sid  (i_req_sid),
    .alloc_ptr  (wptr[i_req_sid]),
    .alloc_tag  (alloc_tag),
    .full       (rob_full),
    .look_tag   (i_host_tag),
    .look_entry (look_entry),
    .done_v     (o_wr_v),
    .done_tag   (wr_tag),
    .rsp_v      (o_rsp_v),
    .rsp_r      (o_rsp_r),
    .rsp_sid    (o_rsp_sid)
  );

  // Clear is applied after the advance so a same-stream clear in the alloc cycle wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < nstrms; s++) begin
        wptr[s] <= '0;
      end
    end else begin
      if (accept) begin
        wptr[i_req_sid] <= ptr_inc(wptr[i_req_sid]);
      end
      if (i_clr_v) begin
        wptr[i_clr_sid] <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_host_v   <= 1'b0;
      o_host_tag <= '0;
      o_host_ea  <= '0;
    end else if (accept) begin
      o_host_v   <= 1'b1;
      o_host_tag <= alloc_tag;
      o_host_ea  <= i_req_ea;
    end else if (o_host_r) begin
      o_host_v   <= 1'b0;
    end
  end

  // Write stage: the URAM write goes out the cycle after the response, and the ROB marks the
  // entry done off the same strobe, so a completion never overtakes its data.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_wr_v   <= 1'b0;
      o_wr_sid <= '0;
      o_wr_ptr <= '0;
      o_wr_d   <= '0;
      wr_tag   <= '0;
      o_err    <= 1'b0;
    end else begin
      o_wr_v <= host_hit;
      if (host_hit) begin
        o_wr_sid <= look_entry.sid;
        o_wr_ptr <= look_entry.ptr;
        o_wr_d   <= i_host_d;
        wr_tag   <= i_host_tag;
      end
      if (i_host_v && !host_hit) begin
        o_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_l2_host_rsp_ctrl.sv
// Self-checking bench for l2_host_rsp_ctrl: a per-cycle vector table, directed multi-cycle
// sequences, and a randomized run checked against a transaction-level model.
module tb_l2_host_rsp_ctrl;
  import l2_pkg::*;

  logic  clk = 1'b0;
  logic  reset;
  logic  i_req_v, i_req_r;
  sid_t  i_req_sid;
  ea_t   i_req_ea;
  logic  o_host_v, o_host_r;
  tag_t  o_host_tag;
  ea_t   o_host_ea;
  logic  i_host_v, i_host_r;
  tag_t  i_host_tag;
  data_t i_host_d;
  logic  o_wr_v;
  sid_t  o_wr_sid;
  ptr_t  o_wr_ptr;
  data_t o_wr_d;
  logic  o_rsp_v, o_rsp_r;
  sid_t  o_rsp_sid;
  logic  i_clr_v;
  sid_t  i_clr_sid;
  logic  o_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  l2_host_rsp_ctrl dut (
    .clk(clk), .reset(reset),
    .i_req_v(i_req_v), .i_req_r(i_req_r), .i_req_sid(i_req_sid), .i_req_ea(i_req_ea),
    .o_host_v(o_host_v), .o_host_r(o_host_r), .o_host_tag(o_host_tag), .o_host_ea(o_host_ea),
    .i_host_v(i_host_v), .i_host_r(i_host_r), .i_host_tag(i_host_tag), .i_host_d(i_host_d),
    .o_wr_v(o_wr_v), .o_wr_sid(o_wr_sid), .o_wr_ptr(o_wr_ptr), .o_wr_d(o_wr_d),
    .o_rsp_v(o_rsp_v), .o_rsp_r(o_rsp_r), .o_rsp_sid(o_rsp_sid),
    .i_clr_v(i_clr_v), .i_clr_sid(i_clr_sid), .o_err(o_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_d(input string name, input data_t act, input data_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: line data differs, got low %0h expected low %0h", name, act[63:0], exp[63:0]);
    end
  endtask

  function automatic data_t mkdata(input int k);
    data_t d;
    for (int i = 0; i < data_width / 32; i++) d[i*32 +: 32] = 32'hA500_0000 ^ (k << 8) ^ i;
    return d;
  endfunction

  function automatic data_t rnddata();
    data_t d;
    for (int i = 0; i < data_width / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_req_v = 0; i_req_sid = '0; i_req_ea = '0; o_host_r = 1; i_host_v = 0; i_host_tag = '0;
    i_host_d = '0; o_rsp_r = 1; i_clr_v = 0; i_clr_sid = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic rst; logic req_v; sid_t sid; ea_t ea; logic host_v; tag_t tag; int dk; logic rsp_r;
    logic x_req_r; logic x_host_v; tag_t x_host_tag; ea_t x_host_ea;
    logic x_wr_v; sid_t x_wr_sid; ptr_t x_wr_ptr; int x_dk;
    logic x_rsp_v; sid_t x_rsp_sid; logic x_err;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t row();
    vec_t r;
    r = '{default: 0};
    r.rsp_r = 1; r.x_req_r = 1;
    return r;
  endfunction

  task automatic fill_table();
    vec_t r;
    // single request sid 3 / ea 0x1000
    r = row(); vt.push_back(r);
    r = row(); r.req_v = 1; r.sid = 3; r.ea = 64'h1000; vt.push_back(r);
    r = row(); r.x_host_v = 1; r.x_host_tag = 0; r.x_host_ea = 64'h1000; vt.push_back(r);
    r = row(); r.host_v = 1; r.tag = 0; r.dk = 1; vt.push_back(r);
    r = row(); r.x_wr_v = 1; r.x_wr_sid = 3; r.x_wr_ptr = 0; r.x_dk = 1; vt.push_back(r);
    r = row(); r.x_rsp_v = 1; r.x_rsp_sid = 3; vt.push_back(r);
    r = row(); r.rst = 1; vt.push_back(r);
    // four requests sid 5, host returns 3,2,1,0
    r = row(); r.req_v = 1; r.sid = 5; r.ea = 64'h2000; vt.push_back(r);
    r = row(); r.req_v = 1; r.sid = 5; r.ea = 64'h2080;
    r.x_host_v = 1; r.x_host_tag = 0; r.x_host_ea = 64'h2000; vt.push_back(r);
    r = row(); r.req_v = 1; r.sid = 5; r.ea = 64'h2100;
    r.x_host_v = 1; r.x_host_tag = 1; r.x_host_ea = 64'h2080; vt.push_back(r);
    r = row(); r.req_v = 1; r.sid = 5; r.ea = 64'h2180;
    r.x_host_v = 1; r.x_host_tag = 2; r.x_host_ea = 64'h2100; vt.push_back(r);
    r = row(); r.x_host_v = 1; r.x_host_tag = 3; r.x_host_ea = 64'h2180; vt.push_back(r);
    r = row(); r.host_v = 1; r.tag = 3; r.dk = 13; vt.push_back(r);
    r = row(); r.host_v = 1; r.tag = 2; r.dk = 12;
    r.x_wr_v = 1; r.x_wr_sid = 5; r.x_wr_ptr = 3; r.x_dk = 13; vt.push_back(r);
    r = row(); r.host_v = 1; r.tag = 1; r.dk = 11;
    r.x_wr_v = 1; r.x_wr_sid = 5; r.x_wr_ptr = 2; r.x_dk = 12; vt.push_back(r);
    r = row(); r.host_v = 1; r.tag = 0; r.dk = 10;
    r.x_wr_v = 1; r.x_wr_sid = 5; r.x_wr_ptr = 1; r.x_dk = 11; vt.push_back(r);
    r = row(); r.x_wr_v = 1; r.x_wr_sid = 5; r.x_wr_ptr = 0; r.x_dk = 10; vt.push_back(r);
    for (int k = 0; k < 4; k++) begin
      r = row(); r.x_rsp_v = 1; r.x_rsp_sid = 5; vt.push_back(r);
    end
    r = row(); vt.push_back(r);
    // stray response while idle
    r = row(); r.host_v = 1; r.tag = 7; r.dk = 7; vt.push_back(r);
    r = row(); r.x_err = 1; vt.push_back(r);
    r = row(); r.rst = 1; r.x_err = 1; vt.push_back(r);
    r = row(); vt.push_back(r);
  endtask

  task automatic run_table();
    foreach (vt[i]) begin
      reset = vt[i].rst; i_req_v = vt[i].req_v; i_req_sid = vt[i].sid; i_req_ea = vt[i].ea;
      i_host_v = vt[i].host_v; i_host_tag = vt[i].tag; i_host_d = mkdata(vt[i].dk);
      o_rsp_r = vt[i].rsp_r; o_host_r = 1; i_clr_v = 0;
      #1;
      check($sformatf("row%0d_req_r", i), 64'(i_req_r), 64'(vt[i].x_req_r));
      check($sformatf("row%0d_host_v", i), 64'(o_host_v), 64'(vt[i].x_host_v));
      if (vt[i].x_host_v) begin
        check($sformatf("row%0d_host_tag", i), 64'(o_host_tag), 64'(vt[i].x_host_tag));
        check($sformatf("row%0d_host_ea", i), o_host_ea, vt[i].x_host_ea);
      end
      check($sformatf("row%0d_wr_v", i), 64'(o_wr_v), 64'(vt[i].x_wr_v));
      if (vt[i].x_wr_v) begin
        check($sformatf("row%0d_wr_sid", i), 64'(o_wr_sid), 64'(vt[i].x_wr_sid));
        check($sformatf("row%0d_wr_ptr", i), 64'(o_wr_ptr), 64'(vt[i].x_wr_ptr));
        check_d($sformatf("row%0d_wr_d", i), o_wr_d, mkdata(vt[i].x_dk));
      end
      check($sformatf("row%0d_rsp_v", i), 64'(o_rsp_v), 64'(vt[i].x_rsp_v));
      if (vt[i].x_rsp_v) check($sformatf("row%0d_rsp_sid", i), 64'(o_rsp_sid), 64'(vt[i].x_rsp_sid));
      check($sformatf("row%0d_err", i), 64'(o_err), 64'(vt[i].x_err));
      tick();
    end
    reset = 0;
    idle_inputs();
  endtask

  // ---------------- directed multi-cycle sequences ----------------
  task automatic seq_full();
    bit got;
    do_reset();
    for (int i = 0; i < ntags; i++) begin
      i_req_v = 1; i_req_sid = sid_t'(i); i_req_ea = 64'(i) << 7;
      #1 check($sformatf("fill%0d_req_r", i), 64'(i_req_r), 64'd1);
      tick();
    end
    i_req_ea = 64'hF000;
    for (int i = 0; i < 2; i++) begin
      #1 check($sformatf("full%0d_req_r", i), 64'(i_req_r), 64'd0);
      tick();
    end
    i_host_v = 1; i_host_tag = '0; i_host_d = mkdata(40);
    #1 check("full_rsp_cycle_req_r", 64'(i_req_r), 64'd0);
    tick();
    i_host_v = 0;
    got = 0;
    for (int k = 0; k < 8 && !got; k++) begin
      #1;
      if (o_rsp_v) begin
        got = 1;
        check("full_retire_cycle_req_r", 64'(i_req_r), 64'd0);
        check("full_retire_sid", 64'(o_rsp_sid), 64'd0);
      end
      tick();
    end
    check("full_retire_seen", 64'(got), 64'd1);
    #1 check("full_resume_req_r", 64'(i_req_r), 64'd1);
    tick();
    i_req_v = 0;
  endtask

  task automatic one_txn(input sid_t sid, input ea_t ea, input int exp_ptr, input bit clr_with,
                         input string nm);
    bit   ok;
    tag_t tag;
    i_req_v = 1; i_req_sid = sid; i_req_ea = ea; i_clr_v = clr_with; i_clr_sid = sid;
    ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      #1 ok = i_req_r;
      tick();
    end
    i_req_v = 0; i_clr_v = 0;
    check({nm, "_accept"}, 64'(ok), 64'd1);
    ok = 0; tag = '0;
    for (int k = 0; k < 20 && !ok; k++) begin
      #1;
      if (o_host_v) begin ok = 1; tag = o_host_tag; end
      tick();
    end
    check({nm, "_host"}, 64'(ok), 64'd1);
    i_host_v = 1; i_host_tag = tag; i_host_d = mkdata(exp_ptr);
    tick();
    i_host_v = 0;
    #1;
    check({nm, "_wr_v"}, 64'(o_wr_v), 64'd1);
    check({nm, "_wr_ptr"}, 64'(o_wr_ptr), 64'(exp_ptr));
    check({nm, "_wr_sid"}, 64'(o_wr_sid), 64'(sid));
    tick();
    #1;
    check({nm, "_rsp_v"}, 64'(o_rsp_v), 64'd1);
    check({nm, "_rsp_sid"}, 64'(o_rsp_sid), 64'(sid));
    tick();
  endtask

  task automatic seq_wrap_clr();
    do_reset();
    for (int i = 0; i <= l2_ncl; i++)
      one_txn(sid_t'(1), 64'(i) << 7, i % l2_ncl, 1'b0, $sformatf("wrap%0d", i));
    one_txn(sid_t'(1), 64'h9000, 1, 1'b0, "post_wrap1");
    one_txn(sid_t'(1), 64'h9080, 2, 1'b0, "post_wrap2");
    i_clr_v = 1; i_clr_sid = sid_t'(1);
    tick();
    i_clr_v = 0;
    one_txn(sid_t'(1), 64'h9100, 0, 1'b0, "after_clr");
    one_txn(sid_t'(1), 64'h9180, 1, 1'b1, "clr_same_cycle");
    one_txn(sid_t'(1), 64'h9200, 0, 1'b0, "clr_wins");
  endtask

  task automatic seq_backpressure();
    do_reset();
    o_host_r = 0; o_rsp_r = 0;
    i_req_v = 1; i_req_sid = sid_t'(9); i_req_ea = 64'hABC0;
    #1 check("bp_first_req_r", 64'(i_req_r), 64'd1);
    tick();
    i_req_ea = 64'hDEAD0;
    for (int k = 0; k < 10; k++) begin
      #1;
      check($sformatf("bp%0d_host_v", k), 64'(o_host_v), 64'd1);
      check($sformatf("bp%0d_host_tag", k), 64'(o_host_tag), 64'd0);
      check($sformatf("bp%0d_host_ea", k), o_host_ea, 64'hABC0);
      check($sformatf("bp%0d_req_r", k), 64'(i_req_r), 64'd0);
      tick();
    end
    i_req_v = 0; o_host_r = 1;
    tick();
    i_host_v = 1; i_host_tag = '0; i_host_d = mkdata(99);
    tick();
    i_host_v = 0;
    tick();
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("stall%0d_rsp_v", k), 64'(o_rsp_v), 64'd1);
      check($sformatf("stall%0d_rsp_sid", k), 64'(o_rsp_sid), 64'd9);
      tick();
    end
    o_rsp_r = 1;
    #1 check("stall_release_rsp_v", 64'(o_rsp_v), 64'd1);
    tick();
    #1 check("stall_after_rsp_v", 64'(o_rsp_v), 64'd0);
    tick();
  endtask

  // ---------------- randomized run against a transaction model ----------------
  typedef struct {
    int sid; int ptr; int tag; bit responded; bit done;
  } txn_t;

  txn_t  q[$];
  int    at_host[$];
  int    m_wptr[nstrms];
  int    m_next_tag;
  bit    m_host_v;
  int    m_host_tag;
  ea_t   m_host_ea;
  bit    m_wr_v;
  int    m_wr_sid, m_wr_ptr, m_wr_tag;
  data_t m_wr_d;
  bit    m_err;

  task automatic seq_random(input int ncyc);
    do_reset();
    q.delete(); at_host.delete();
    foreach (m_wptr[s]) m_wptr[s] = 0;
    m_next_tag = 0; m_host_v = 0; m_host_tag = 0; m_host_ea = '0;
    m_wr_v = 0; m_wr_sid = 0; m_wr_ptr = 0; m_wr_tag = 0; m_wr_d = '0; m_err = 0;
    for (int c = 0; c < ncyc; c++) begin
      bit    rv, hr, rr, hv, cv, x_req_r, x_rsp_v, acc, hit;
      int    rs, cs, ht, hidx;
      ea_t   re;
      data_t hd;
      rv = ($urandom % 2) == 0; rs = $urandom % 4; re = {$urandom, $urandom};
      hr = ($urandom % 4) != 0; rr = ($urandom % 3) != 0;
      cv = ($urandom % 24) == 0; cs = $urandom % 4;
      hv = 0; ht = 0; hd = rnddata();
      if (at_host.size() > 0 && ($urandom % 2) == 0) begin
        hidx = $urandom % at_host.size();
        ht = at_host[hidx];
        at_host.delete(hidx);
        hv = 1;
      end
      i_req_v = rv; i_req_sid = sid_t'(rs); i_req_ea = re; o_host_r = hr; o_rsp_r = rr;
      i_clr_v = cv; i_clr_sid = sid_t'(cs); i_host_v = hv; i_host_tag = tag_t'(ht); i_host_d = hd;
      #1;
      x_req_r = (q.size() < ntags) && (!m_host_v || hr);
      x_rsp_v = (q.size() > 0) && q[0].done;
      check($sformatf("rnd%0d_req_r", c), 64'(i_req_r), 64'(x_req_r));
      check($sformatf("rnd%0d_host_v", c), 64'(o_host_v), 64'(m_host_v));
      if (m_host_v) begin
        check($sformatf("rnd%0d_host_tag", c), 64'(o_host_tag), 64'(m_host_tag));
        check($sformatf("rnd%0d_host_ea", c), o_host_ea, m_host_ea);
      end
      check($sformatf("rnd%0d_wr_v", c), 64'(o_wr_v), 64'(m_wr_v));
      if (m_wr_v) begin
        check($sformatf("rnd%0d_wr_sid", c), 64'(o_wr_sid), 64'(m_wr_sid));
        check($sformatf("rnd%0d_wr_ptr", c), 64'(o_wr_ptr), 64'(m_wr_ptr));
        check_d($sformatf("rnd%0d_wr_d", c), o_wr_d, m_wr_d);
      end
      check($sformatf("rnd%0d_rsp_v", c), 64'(o_rsp_v), 64'(x_rsp_v));
      if (x_rsp_v) check($sformatf("rnd%0d_rsp_sid", c), 64'(o_rsp_sid), 64'(q[0].sid));

      // advance the model across this clock edge
      acc = rv && x_req_r;
      if (m_host_v && hr) at_host.push_back(m_host_tag);
      if (m_wr_v) foreach (q[j]) if (q[j].tag == m_wr_tag) q[j].done = 1;
      if (x_rsp_v && rr) void'(q.pop_front());
      m_wr_v = 0;
      if (hv) begin
        hit = 0;
        foreach (q[j]) begin
          if (q[j].tag == ht && !q[j].responded) begin
            hit = 1; q[j].responded = 1;
            m_wr_v = 1; m_wr_sid = q[j].sid; m_wr_ptr = q[j].ptr; m_wr_tag = ht; m_wr_d = hd;
          end
        end
        if (!hit) m_err = 1;
      end
      if (acc) begin
        q.push_back('{sid: rs, ptr: m_wptr[rs], tag: m_next_tag, responded: 0, done: 0});
        m_wptr[rs] = (m_wptr[rs] + 1) % l2_ncl;
        m_host_v = 1; m_host_tag = m_next_tag; m_host_ea = re;
        m_next_tag = (m_next_tag + 1) % ntags;
      end else if (hr) begin
        m_host_v = 0;
      end
      if (cv) m_wptr[cs] = 0;
      tick();
    end
    idle_inputs();
    #1 check("rnd_err", 64'(o_err), 64'(m_err));
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1;
    idle_inputs();
    do_reset();
    fill_table();
    run_table();
    seq_full();
    seq_wrap_clr();
    seq_backpressure();
    seq_random(3000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
